// File: rtl/axis_bc_pkg.sv
// Shared constants for the AXI-Stream N-way broadcaster: pointer/level widths
// derived from buffer depth and the statistics counter width.
package axis_bc_pkg;

   localparam int CNT_W = 32;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // One extra bit so the level can represent a completely full buffer.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/axis_bc_fifo.sv
// Per-channel buffer for the broadcaster: power-of-two circular FIFO with a
// registered occupancy level; head beat is presented combinationally.
module axis_bc_fifo
   import axis_bc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        din,
   input  logic                     ready,
   output logic                     valid,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic [lvl_w(DEPTH)-1:0]  level
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int LVL_W = lvl_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign valid   = (level != '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = valid & ready;
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)
            level <= level + LVL_W'(1);
         else if (!do_push && do_pop)
            level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/axis_broadcaster_n.sv
// AXI-Stream 1-to-N broadcaster with an independent FIFO per output channel.
// Optional per-channel delivered-beat counters when AXIS_BC_STATS_EN is defined.
module axis_broadcaster_n
   import axis_bc_pkg::*;
#(
   parameter int C_DATA_WIDTH = 32,
   parameter int C_NUM_CH     = 2,
   parameter int C_BUF_DEPTH  = 4
)(
   input  logic                                   i_aclk,
   input  logic                                   i_reset,
   input  logic                                   s_axis_tvalid,
   output logic                                   s_axis_tready,
   input  logic [C_DATA_WIDTH-1:0]                s_axis_tdata,
   input  logic [C_NUM_CH-1:0]                    i_ch_enable,
   output logic [C_NUM_CH-1:0]                    m_axis_tvalid,
   input  logic [C_NUM_CH-1:0]                    m_axis_tready,
   output logic [C_NUM_CH*C_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_NUM_CH*lvl_w(C_BUF_DEPTH)-1:0] o_ch_level
`ifdef AXIS_BC_STATS_EN
   ,
   input  logic                                   i_stats_clear,
   output logic [C_NUM_CH*CNT_W-1:0]              o_beat_count
`endif
);

   localparam int LVL_W = lvl_w(C_BUF_DEPTH);

   logic [C_NUM_CH-1:0] ch_full;
   logic                accept;

   // Handshake: a beat transfers on a rising edge where valid and ready are both
   // high; ready never depends on valid or on downstream ready, only on registered
   // FIFO fullness of the enabled channels, so a channel popping while full still
   // blocks input for that cycle.
   assign s_axis_tready = ~i_reset & ~|(ch_full & i_ch_enable);
   assign accept        = s_axis_tvalid & s_axis_tready;

   for (genvar n = 0; n < C_NUM_CH; n++) begin : g_ch
      axis_bc_fifo #(
         .DATA_W (C_DATA_WIDTH),
         .DEPTH  (C_BUF_DEPTH)
      ) u_fifo (
         .clk   (i_aclk),
         .rst   (i_reset),
         .push  (accept & i_ch_enable[n]),
         .din   (s_axis_tdata),
         .ready (m_axis_tready[n]),
         .valid (m_axis_tvalid[n]),
         .dout  (m_axis_tdata[n*C_DATA_WIDTH +: C_DATA_WIDTH]),
         .full  (ch_full[n]),
         .level (o_ch_level[n*LVL_W +: LVL_W])
      );

`ifdef AXIS_BC_STATS_EN
      logic [CNT_W-1:0] beat_cnt;

      // Clear has priority over a coincident delivery.
      always_ff @(posedge i_aclk) begin
         if (i_reset || i_stats_clear)
            beat_cnt <= '0;
         else if (m_axis_tvalid[n] && m_axis_tready[n])
            beat_cnt <= beat_cnt + CNT_W'(1);
      end

      assign o_beat_count[n*CNT_W +: CNT_W] = beat_cnt;
`endif
   end

endmodule

// File: tb/tb_axis_broadcaster_n.sv
// Self-checking bench for axis_broadcaster_n (3 channels, depth 4) with
// per-channel expected queues; stats checks compiled in with AXIS_BC_STATS_EN.
module tb_axis_broadcaster_n;

   localparam int W   = 32;
   localparam int NCH = 3;
   localparam int LW  = 3;

   logic            clk = 1'b0;
   logic            i_reset;
   logic            s_axis_tvalid;
   logic            s_axis_tready;
   logic [W-1:0]    s_axis_tdata;
   logic [NCH-1:0]  i_ch_enable;
   logic [NCH-1:0]  m_axis_tvalid;
   logic [NCH-1:0]  m_axis_tready;
   logic [NCH*W-1:0]  m_axis_tdata;
   logic [NCH*LW-1:0] o_ch_level;
`ifdef AXIS_BC_STATS_EN
   logic              i_stats_clear;
   logic [NCH*32-1:0] o_beat_count;
`endif

   axis_broadcaster_n #(
      .C_DATA_WIDTH (W),
      .C_NUM_CH     (NCH),
      .C_BUF_DEPTH  (4)
   ) dut (
      .i_aclk        (clk),
      .i_reset       (i_reset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .i_ch_enable   (i_ch_enable),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .o_ch_level    (o_ch_level)
`ifdef AXIS_BC_STATS_EN
      ,
      .i_stats_clear (i_stats_clear),
      .o_beat_count  (o_beat_count)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q [NCH][$];
   int rx_cnt [NCH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver: call at posedge+1; pushes expected beats when the DUT accepts
   task automatic send_beat(input logic [W-1:0] d, input logic [NCH-1:0] en, output int waited);
      waited        = 0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      i_ch_enable   = en;
      @(negedge clk);
      while (!s_axis_tready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!s_axis_tready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept timeout: data 0x%0h not accepted, expected acceptance", d);
      end else begin
         for (int c = 0; c < NCH; c++)
            if (en[c]) exp_q[c].push_back(d);
      end
      step();
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_many(input logic [W-1:0] first, input int cnt, input logic [NCH-1:0] en);
      int w;
      for (int i = 0; i < cnt; i++) send_beat(first + W'(i), en, w);
   endtask

   // monitor / scoreboard
   task automatic monitor_loop();
      logic [NCH-1:0] pv;
      logic [NCH-1:0] pr;
      logic [NCH*W-1:0] pd;
      logic have_prev;
      have_prev = 1'b0;
      pv = '0;
      pr = '0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (i_reset) begin
            have_prev = 1'b0;
         end else begin
            for (int c = 0; c < NCH; c++) begin
               if (have_prev && pv[c] && !pr[c]) begin
                  check($sformatf("ch%0d stall valid", c), 32'(m_axis_tvalid[c]), 32'd1);
                  check($sformatf("ch%0d stall data", c), m_axis_tdata[c*W +: W], pd[c*W +: W]);
               end
               if (m_axis_tvalid[c] && m_axis_tready[c]) begin
                  if (exp_q[c].size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL ch%0d unexpected beat: got 0x%0h, expected none", c, m_axis_tdata[c*W +: W]);
                  end else begin
                     check($sformatf("ch%0d data", c), m_axis_tdata[c*W +: W], exp_q[c].pop_front());
                  end
                  rx_cnt[c]++;
               end
            end
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            pd = m_axis_tdata;
            have_prev = 1'b1;
         end
      end
   endtask

   task automatic check_drained(input string tag, input int exp_rx0, input int exp_rx1, input int exp_rx2);
      check({tag, " rx ch0"}, rx_cnt[0], exp_rx0);
      check({tag, " rx ch1"}, rx_cnt[1], exp_rx1);
      check({tag, " rx ch2"}, rx_cnt[2], exp_rx2);
      check({tag, " pending"}, exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
   endtask

   initial begin
      int w;
      i_reset       = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      i_ch_enable   = 3'b111;
      m_axis_tready = 3'b111;
`ifdef AXIS_BC_STATS_EN
      i_stats_clear = 1'b0;
`endif
      for (int c = 0; c < NCH; c++) rx_cnt[c] = 0;
      fork
         monitor_loop();
      join_none

      // reset state
      repeat (3) step();
      @(negedge clk);
      check("tready in reset", 32'(s_axis_tready), 32'd0);
      step();
      i_reset = 1'b0;
      @(negedge clk);
      check("reset tvalid", 32'(m_axis_tvalid), 32'd0);
      check("reset level", 32'(o_ch_level), 32'd0);
      check("tready after reset", 32'(s_axis_tready), 32'd1);
      step();

      // all channels ready: 0x1..0x10, first valid one cycle after acceptance
      send_beat(32'h1, 3'b111, w);
      check("first beat wait", w, 0);
      @(negedge clk);
      check("latency tvalid", 32'(m_axis_tvalid), 32'h7);
      step();
      send_many(32'h2, 15, 3'b111);
      repeat (3) @(negedge clk);
      check_drained("s1", 16, 16, 16);
      step();

      // backpressure on channel 1
      m_axis_tready = 3'b101;
      send_many(32'h21, 4, 3'b111);
      @(negedge clk);
      check("bp tready", 32'(s_axis_tready), 32'd0);
      check("bp level ch1", 32'(o_ch_level[LW +: LW]), 32'd4);
      check("bp level ch0", 32'(o_ch_level[0 +: LW]), 32'd1);
      step();
      fork
         send_beat(32'h25, 3'b111, w);
         begin
            step();
            step();
            m_axis_tready = 3'b111;
            @(negedge clk);
            check("full+pop tready", 32'(s_axis_tready), 32'd0);
         end
      join
      repeat (6) @(negedge clk);
      check_drained("s2", 21, 21, 21);
      step();

      // channel 1 disabled
      send_many(32'hA, 3, 3'b101);
      repeat (3) @(negedge clk);
      check("s3 ch1 valid", 32'(m_axis_tvalid[1]), 32'd0);
      check_drained("s3", 24, 21, 24);
      step();

      // sink mode
      for (int i = 0; i < 5; i++) begin
         send_beat(32'h40 + W'(i), 3'b000, w);
         check("sink wait", w, 0);
      end
      repeat (2) @(negedge clk);
      check("sink tvalid", 32'(m_axis_tvalid), 32'd0);
      check_drained("s4", 24, 21, 24);
      step();

      // reset with 3 beats buffered
      m_axis_tready = 3'b000;
      send_many(32'h51, 3, 3'b111);
      @(negedge clk);
      check("pre-reset level", 32'(o_ch_level), {23'd0, 3'd3, 3'd3, 3'd3});
      step();
      i_reset = 1'b1;
      @(negedge clk);
      check("tready during reset", 32'(s_axis_tready), 32'd0);
      step();
      for (int c = 0; c < NCH; c++) exp_q[c].delete();
      @(negedge clk);
      check("post-reset tvalid", 32'(m_axis_tvalid), 32'd0);
      check("post-reset level", 32'(o_ch_level), 32'd0);
      step();
      i_reset       = 1'b0;
      m_axis_tready = 3'b111;
      repeat (3) @(negedge clk);
      check("reset no delivery", 32'(m_axis_tvalid), 32'd0);
      check("tready after mid reset", 32'(s_axis_tready), 32'd1);
      check_drained("s5", 24, 21, 24);
      step();

`ifdef AXIS_BC_STATS_EN
      i_stats_clear = 1'b1;
      step();
      i_stats_clear = 1'b0;
      send_many(32'h61, 7, 3'b001);
      repeat (3) @(negedge clk);
      check("beat count ch0", o_beat_count[0 +: 32], 32'd7);
      check("beat count ch1", o_beat_count[32 +: 32], 32'd0);
      step();
      i_stats_clear = 1'b1;
      step();
      i_stats_clear = 1'b0;
      @(negedge clk);
      check("beat count cleared", o_beat_count[0 +: 32], 32'd0);
      step();
`endif

      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
